// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART core: FSM state encodings, the
// oversampling constant and elaboration-time configuration checks.
package uart_pkg;

    localparam int TICKS_PER_BIT = 4;
    localparam int PHASE_W       = $clog2(TICKS_PER_BIT);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_WAIT,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int calc_div(input int freq, input int baud);
        return freq / (baud * TICKS_PER_BIT);
    endfunction

    function automatic bit cfg_ok(input int freq, input int baud, input int data_bits,
                                  input int stop_bits, input int depth);
        return (calc_div(freq, baud) >= 2) &&
               (data_bits >= 5) && (data_bits <= 8) &&
               ((stop_bits == 1) || (stop_bits == 2)) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a registered head word; push and pop may share a cycle,
// including when full (the pop frees the slot the push fills).
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Head tracks what rd_ptr will point at after this edge; an incoming
            // word bypasses memory when it becomes the new head.
            if ((empty && do_push) || (do_pop && do_push && count == CNT_ONE)) begin
                dout <= din;
            end else if (do_pop && count != CNT_ONE) begin
                dout <= mem[rd_ptr + PTR_W'(1)];
            end
        end
    end

endmodule

// File: rtl/uart_core.sv
// UART core: free-running baud tick (4 per bit), transmitter, 4x-oversampled
// receiver and RX FIFO. Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core
    import uart_pkg::*;
#(
    parameter int FREQUENCY     = 11059200,
    parameter int BAUD          = 9600,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 8
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
`ifdef UART_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int DIV   = calc_div(FREQUENCY, BAUD);
    localparam int DIV_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0]   DATA_LAST   = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]   STOP_LAST   = BIT_W'(STOP_BITS - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(TICKS_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] START_PHASE = PHASE_W'(1);

    if (!cfg_ok(FREQUENCY, BAUD, DATA_BITS, STOP_BITS, RX_FIFO_DEPTH)) begin : g_bad_cfg
        $error("uart_core: unsupported FREQUENCY/BAUD/DATA_BITS/STOP_BITS/RX_FIFO_DEPTH");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk) begin
        if (res) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state;
    tx_state_t            tx_next;
    logic [PHASE_W-1:0]   tx_phase;
    logic [BIT_W-1:0]     tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = tick && (tx_phase == PHASE_LAST);

    always_ff @(posedge clk) begin
        if (res) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_valid) tx_next = TX_WAIT;
            TX_WAIT:   if (tick) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA: begin
                if (tx_bit_end && tx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    tx_next = TX_PARITY;
`else
                    tx_next = TX_STOP;
`endif
                end
            end
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_bit_end && tx_bit == STOP_LAST) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE);
        case (tx_state)
            TX_START:  tx = 1'b0;
            TX_DATA:   tx = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx = tx_par;
`endif
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            tx_phase <= '0;
            tx_bit   <= '0;
        end else begin
            if (tx_state == TX_IDLE || tx_state == TX_WAIT) begin
                tx_phase <= '0;
            end else if (tick) begin
                tx_phase <= tx_phase + PHASE_W'(1);
            end
            if (tx_next != tx_state) begin
                tx_bit <= '0;
            end else if (tx_bit_end) begin
                tx_bit <= tx_bit + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_state == TX_IDLE && tx_valid) begin
            tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= (^tx_data) ^ PARITY_ODD;
`endif
        end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_p0;
    logic                 rx_p1;
    rx_state_t            rx_state;
    rx_state_t            rx_next;
    logic [PHASE_W-1:0]   rx_phase;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_sample;
    logic                 rx_push;
    logic                 frame_err_d;
    logic                 fifo_empty;
    logic                 fifo_full;
`ifdef UART_PARITY_EN
    logic                 rx_par_bit;
    logic                 parity_err_d;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    // START re-checks the line two ticks in (mid start bit); later bits are 4 ticks apart.
    assign rx_sample = tick && ((rx_state == RX_START) ? (rx_phase == START_PHASE)
                                                       : (rx_phase == PHASE_LAST));

    always_ff @(posedge clk) begin
        if (res) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (tick && !rx_p1) rx_next = RX_START;
            RX_START:  if (rx_sample) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_sample && rx_bit == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    rx_next = RX_PARITY;
`else
                    rx_next = RX_STOP;
`endif
                end
            end
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push      = (rx_state == RX_STOP) && rx_sample && rx_p1;
        frame_err_d  = (rx_state == RX_STOP) && rx_sample && !rx_p1;
`ifdef UART_PARITY_EN
        parity_err_d = (rx_state == RX_STOP) && rx_sample &&
                       (rx_par_bit != ((^rx_shift) ^ PARITY_ODD));
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rx_phase <= '0;
            rx_bit   <= '0;
        end else begin
            if (rx_next != rx_state) begin
                rx_phase <= '0;
            end else if (tick && rx_state != RX_IDLE) begin
                rx_phase <= rx_phase + PHASE_W'(1);
            end
            if (rx_next != rx_state) begin
                rx_bit <= '0;
            end else if (rx_sample && rx_state == RX_DATA) begin
                rx_bit <= rx_bit + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_sample) begin
            rx_shift <= {rx_p1, rx_shift[DATA_BITS-1:1]};
        end
`ifdef UART_PARITY_EN
        if (rx_state == RX_PARITY && rx_sample) begin
            rx_par_bit <= rx_p1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err  <= frame_err_d;
            rx_overrun    <= rx_push && fifo_full && !rx_ready;
`ifdef UART_PARITY_EN
            rx_parity_err <= parity_err_d;
`endif
        end
    end

    uart_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk  (clk),
        .res  (res),
        .push (rx_push),
        .din  (rx_shift),
        .pop  (rx_ready),
        .dout (rx_data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at FREQUENCY=400, BAUD=10 (10 clk per tick,
// 40 clk per bit); expected line bits and received bytes come from a frame model.
module tb_uart_core;

    localparam int DIV  = 10;
    localparam int BITC = 40;
`ifdef UART_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 1 + 8 + PBITS + 1;
    localparam int FRAME = NBITS * BITC;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       rx;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       tx;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_PARITY_EN
    logic       rx_parity_err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fe_seen   = 0;
    int ov_seen   = 0;
    int pe_seen   = 0;
    logic [7:0] got[$];

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core #(
        .FREQUENCY(400),
        .BAUD(10)
    ) dut (
        .clk          (clk),
        .res          (res),
        .rx           (rx),
        .tx           (tx),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
`ifdef UART_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) fe_seen <= fe_seen + 1;
        if (rx_overrun === 1'b1) ov_seen <= ov_seen + 1;
`ifdef UART_PARITY_EN
        if (rx_parity_err === 1'b1) pe_seen <= pe_seen + 1;
`endif
    end

    // Line level of bit k of a frame carrying b: start, data LSB first, even parity, stop.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PBITS == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Records the head if it is being popped at the coming edge, then advances a cycle.
    task automatic cyc();
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
        @(negedge clk);
    endtask

    task automatic send_and_check(input logic [7:0] b);
        int t;
        int rdy_at;
        t = 0;
        while (tx_ready !== 1'b1 && t < 2000) begin
            cyc();
            t++;
        end
        total_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL tx_ready_wait: got %b want 1", tx_ready);
        else pass_cnt++;
        tx_data  = b;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        total_cnt++;
        if (tx_ready !== 1'b0) $display("FAIL tx_ready_drop: got %b want 0", tx_ready);
        else pass_cnt++;
        t = 0;
        while (tx !== 1'b0 && t <= DIV + 2) begin
            cyc();
            t++;
        end
        total_cnt++;
        if (tx !== 1'b0) $display("FAIL tx_start_latency: no start bit within %0d clk", t);
        else pass_cnt++;
        rdy_at = -1;
        for (int i = 1; i <= FRAME + 5; i++) begin
            cyc();
            if (i % BITC == BITC / 2 && i / BITC < NBITS) begin
                total_cnt++;
                if (tx !== exp_bit(b, i / BITC) || tx_ready !== 1'b0)
                    $display("FAIL tx_bit%0d byte %h: got tx=%b ready=%b want tx=%b ready=0",
                             i / BITC, b, tx, tx_ready, exp_bit(b, i / BITC));
                else pass_cnt++;
            end
            if (tx_ready === 1'b1 && rdy_at < 0) rdy_at = i;
        end
        total_cnt++;
        if (rdy_at != FRAME) $display("FAIL tx_frame_len byte %h: got %0d want %0d", b, rdy_at, FRAME);
        else pass_cnt++;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_val, input logic par_flip,
                               output logic seen_valid);
        logic bv;
        seen_valid = 1'b0;
        repeat ($urandom_range(0, DIV - 1)) cyc();
        for (int k = 0; k < NBITS; k++) begin
            bv = exp_bit(b, k);
            if (k == NBITS - 1) bv = stop_val;
            if (PBITS == 1 && k == 9 && par_flip) bv = ~bv;
            rx_drv = bv;
            for (int c = 0; c < BITC; c++) begin
                if (rx_valid === 1'b1) seen_valid = 1'b1;
                cyc();
            end
        end
        rx_drv = 1'b1;
        for (int c = 0; c < 2 * BITC; c++) begin
            if (rx_valid === 1'b1) seen_valid = 1'b1;
            cyc();
        end
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (3) cyc();
        total_cnt++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
        total_cnt++;
        if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", tx_ready); else pass_cnt++;
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else pass_cnt++;
        total_cnt++;
        if (rx_frame_err !== 1'b0 || rx_overrun !== 1'b0)
            $display("FAIL reset_err: got fe=%b ov=%b want 0 0", rx_frame_err, rx_overrun);
        else pass_cnt++;
        res = 1'b0;
        cyc();
    endtask

    task automatic test_tx_pattern();
        loop_en = 1'b0;
        send_and_check(8'hA5);
        for (int i = 0; i < 3; i++) send_and_check(8'($urandom));
    endtask

    task automatic test_loopback();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int fe0;
        int ov0;
        fe0 = fe_seen;
        ov0 = ov_seen;
        got.delete();
        loop_en  = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : (i == 2) ? 8'h3C : 8'($urandom);
            exp_q.push_back(b);
            send_and_check(b);
        end
        repeat (60) cyc();
        total_cnt++;
        if (got.size() != exp_q.size()) $display("FAIL loop_count: got %0d want %0d", got.size(), exp_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total_cnt++;
            if (got[i] !== exp_q[i]) $display("FAIL loop_data%0d: got %h want %h", i, got[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (fe_seen != fe0 || ov_seen != ov0)
            $display("FAIL loop_errors: got fe=%0d ov=%0d want 0 0", fe_seen - fe0, ov_seen - ov0);
        else pass_cnt++;
        rx_ready = 1'b0;
        loop_en  = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int ov0;
        got.delete();
        loop_en  = 1'b1;
        rx_ready = 1'b0;
        ov0 = ov_seen;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            if (i == 8) begin
                total_cnt++;
                if (ov_seen != ov0) $display("FAIL overrun_early: got %0d want 0", ov_seen - ov0);
                else pass_cnt++;
            end
            send_and_check(b);
        end
        repeat (60) cyc();
        total_cnt++;
        if (ov_seen - ov0 != 1) $display("FAIL overrun_count: got %0d want 1", ov_seen - ov0);
        else pass_cnt++;
        total_cnt++;
        if (rx_valid !== 1'b1) $display("FAIL overrun_valid: got %b want 1", rx_valid); else pass_cnt++;
        rx_ready = 1'b1;
        repeat (12) cyc();
        rx_ready = 1'b0;
        cyc();
        total_cnt++;
        if (got.size() != 8) $display("FAIL overrun_held: got %0d want 8", got.size()); else pass_cnt++;
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            total_cnt++;
            if (got[i] !== exp_q[i]) $display("FAIL overrun_data%0d: got %h want %h", i, got[i], exp_q[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (rx_valid !== 1'b0) $display("FAIL overrun_drained: got %b want 0", rx_valid); else pass_cnt++;
        loop_en = 1'b0;
    endtask

    task automatic test_frame_err();
        logic seen;
        int fe0;
        fe0 = fe_seen;
        drive_frame(8'h55, 1'b0, 1'b0, seen);
        total_cnt++;
        if (fe_seen - fe0 != 1) $display("FAIL frame_err_count: got %0d want 1", fe_seen - fe0);
        else pass_cnt++;
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL frame_err_push: got rx_valid=%b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_rx_direct();
        logic seen;
        logic [7:0] b;
        int fe0;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            fe0 = fe_seen;
            drive_frame(b, 1'b1, 1'b0, seen);
            total_cnt++;
            if (rx_valid !== 1'b1 || rx_data !== b || fe_seen != fe0)
                $display("FAIL rx_direct%0d: got valid=%b data=%h fe=%0d want 1 %h 0",
                         i, rx_valid, rx_data, fe_seen - fe0, b);
            else pass_cnt++;
            rx_ready = 1'b1;
            cyc();
            rx_ready = 1'b0;
            total_cnt++;
            if (rx_valid !== 1'b0) $display("FAIL rx_direct_pop%0d: got %b want 0", i, rx_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        logic seen;
        int fe0;
        fe0 = fe_seen;
        seen = 1'b0;
        repeat ($urandom_range(0, DIV - 1)) cyc();
        rx_drv = 1'b0;
        repeat (15) cyc();
        rx_drv = 1'b1;
        for (int c = 0; c < 3 * BITC; c++) begin
            if (rx_valid === 1'b1) seen = 1'b1;
            cyc();
        end
        total_cnt++;
        if (seen !== 1'b0 || fe_seen != fe0)
            $display("FAIL glitch: got valid=%b fe=%0d want 0 0", seen, fe_seen - fe0);
        else pass_cnt++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic seen;
        int pe0;
        int fe0;
        send_and_check(8'h07);
        pe0 = pe_seen;
        fe0 = fe_seen;
        drive_frame(8'h07, 1'b1, 1'b1, seen);
        total_cnt++;
        if (pe_seen - pe0 != 1 || fe_seen != fe0)
            $display("FAIL parity_err: got pe=%0d fe=%0d want 1 0", pe_seen - pe0, fe_seen - fe0);
        else pass_cnt++;
        total_cnt++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h07)
            $display("FAIL parity_push: got valid=%b data=%h want 1 07", rx_valid, rx_data);
        else pass_cnt++;
        rx_ready = 1'b1;
        cyc();
        rx_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_tx();
        logic [7:0] b;
        int t;
        b = 8'($urandom);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        t = 0;
        while (tx !== 1'b0 && t <= DIV + 2) begin
            cyc();
            t++;
        end
        repeat (4 * BITC + BITC / 2) cyc();
        total_cnt++;
        if (tx !== exp_bit(b, 4)) $display("FAIL mid_bit3: got %b want %b", tx, exp_bit(b, 4));
        else pass_cnt++;
        res = 1'b1;
        cyc();
        total_cnt++;
        if (tx !== 1'b1 || tx_ready !== 1'b1)
            $display("FAIL mid_reset: got tx=%b ready=%b want 1 1", tx, tx_ready);
        else pass_cnt++;
        res = 1'b0;
        cyc();
        send_and_check(8'($urandom));
    endtask

    initial begin
        test_reset();
        test_tx_pattern();
        test_loopback();
        test_overrun();
        test_frame_err();
        test_rx_direct();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
